multi_digit_timer_display: RTL and testbench



---
 rtl/timer_disp_pkg.sv | 27 ++
 rtl/bcd_updown_digit.sv | 39 +++
 rtl/multi_digit_timer_display.sv | 151 +++++++++++++++
 tb/tb_multi_digit_timer_display.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/timer_disp_pkg.sv
// Shared types and constants for the multi-digit timer/display: FSM states,
// active-low {g..a} segment patterns and BCD helpers.
package timer_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // Indices 10..15 are not valid BCD and render dark.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
        SEG_BLANK, SEG_BLANK, SEG_BLANK,
        SEG_BLANK, SEG_BLANK, SEG_BLANK
    };

    function automatic logic [3:0] sat_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_updown_digit.sv
// One BCD digit of the timer chain: synchronous load, stepping gated by en and
// the ripple input cin, up (carry 9->0) or down (borrow 0->9). stepped is combinational.
module bcd_updown_digit
    import timer_disp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] value,
    output logic [3:0] stepped,
    output logic       cout
);

    always_comb begin
        stepped = value;
        if (cin) begin
            if (up)
                stepped = (value >= BCD_MAX) ? 4'd0 : value + 4'd1;
            else
                stepped = (value == 4'd0) ? BCD_MAX : value - 4'd1;
        end
    end

    assign cout = cin && (up ? (value >= BCD_MAX) : (value == 4'd0));

    always_ff @(posedge clk) begin
        if (!reset)
            value <= 4'd0;
        else if (load)
            value <= load_val;
        else if (en)
            value <= stepped;
    end

endmodule

// File: rtl/multi_digit_timer_display.sv
// BCD up/down timer with scanned 7-segment output, all slow rates via clock enables.
// Optional EXPIRE_BLINK_EN: flash the display at TICK_HZ/2 while expired.
module multi_digit_timer_display
    import timer_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 1,
    parameter int SCAN_HZ    = 1000
) (
    input  logic                    orig_clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    mode_up,
    input  logic [4*NUM_DIGITS-1:0] load_bcd,
    output logic                    running,
    output logic                    time_out,
    output logic                    done_pulse,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = 4 * NUM_DIGITS;

    state_t          state, state_nxt;
    logic            mode_r;
    logic [CW-1:0]   limit_r, load_sat, count, stepped;
    logic [NUM_DIGITS:0] carry;
    logic [TW-1:0]   tick_cnt;
    logic [SW-1:0]   scan_cnt;
    logic [IW-1:0]   idx;
    logic [3:0]      cur_digit;
    logic            tick_adv, tick_en, step, scan_en, at_term, load_term, blank;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign load_sat[4*i +: 4] = sat_digit(load_bcd[4*i +: 4]);
        bcd_updown_digit u_digit (
            .clk      (orig_clk),
            .reset    (reset),
            .load     (start),
            .load_val (mode_up ? 4'd0 : load_sat[4*i +: 4]),
            .en       (step),
            .up       (mode_r),
            .cin      (carry[i]),
            .value    (count[4*i +: 4]),
            .stepped  (stepped[4*i +: 4]),
            .cout     (carry[i+1])
        );
    end

`ifdef EXPIRE_BLINK_EN
    assign tick_adv = (state == RUN && !pause) || state == EXPIRED;
`else
    assign tick_adv = (state == RUN && !pause);
`endif
    assign tick_en = tick_adv && (tick_cnt == TW'(TICK_DIV - 1));
    assign step    = tick_en && (state == RUN);

    // Up-mode start counts from 0, so both directions load terminal iff the limit is 0.
    assign load_term = (load_sat == '0);
    // A ripple out of the top digit would wrap the count; treat it as terminal.
    assign at_term   = (stepped == (mode_r ? limit_r : '0)) || carry[NUM_DIGITS];

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = load_term ? EXPIRED : RUN;
        end else begin
            case (state)
                RUN: begin
                    if (pause)
                        state_nxt = PAUSED;
                    else if (step && at_term)
                        state_nxt = EXPIRED;
                end
                PAUSED:  if (!pause) state_nxt = RUN;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge orig_clk) begin
        if (!reset) begin
            state      <= IDLE;
            mode_r     <= 1'b0;
            limit_r    <= '0;
            tick_cnt   <= '0;
            running    <= 1'b0;
            time_out   <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            running    <= (state_nxt == RUN);
            time_out   <= (state_nxt == EXPIRED);
            done_pulse <= (state_nxt == EXPIRED) && (state != EXPIRED || start);
            if (start) begin
                mode_r   <= mode_up;
                limit_r  <= load_sat;
                tick_cnt <= '0;
            end else if (tick_adv) begin
                tick_cnt <= tick_en ? '0 : tick_cnt + 1'b1;
            end
        end
    end

`ifdef EXPIRE_BLINK_EN
    logic blink_off;
    always_ff @(posedge orig_clk) begin
        if (!reset || state_nxt != EXPIRED)
            blink_off <= 1'b0;
        else if (tick_en)
            blink_off <= ~blink_off;
    end
    assign blank = blink_off && (state_nxt == EXPIRED);
`else
    assign blank = 1'b0;
`endif

    assign scan_en = (scan_cnt == SW'(SCAN_DIV - 1));

    always_comb begin
        cur_digit = count[3:0];
        for (int i = 1; i < NUM_DIGITS; i++)
            if (idx == IW'(i)) cur_digit = count[4*i +: 4];
    end

    // seg and an share one register stage so a digit never shows its neighbour's pattern.
    always_ff @(posedge orig_clk) begin
        if (!reset) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg      <= SEG_BLANK;
            an       <= '1;
        end else begin
            scan_cnt <= scan_en ? '0 : scan_cnt + 1'b1;
            if (scan_en)
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            seg <= SEG_LUT[cur_digit];
            an  <= blank ? '1 : ~(NUM_DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_multi_digit_timer_display.sv
// Directed bench for multi_digit_timer_display: 3 digits, tick every 10 cycles,
// scan step every 2 cycles; inputs driven and outputs sampled 1 time unit after posedge.
module tb_multi_digit_timer_display;

    logic        orig_clk;
    logic        reset, start, pause, mode_up;
    logic [11:0] load_bcd;
    logic        running, time_out, done_pulse;
    logic [6:0]  seg;
    logic [2:0]  an;

    int passed = 0;
    int total  = 0;

    multi_digit_timer_display #(
        .NUM_DIGITS (3),
        .CLK_HZ     (100),
        .TICK_HZ    (10),
        .SCAN_HZ    (50)
    ) dut (
        .orig_clk   (orig_clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .mode_up    (mode_up),
        .load_bcd   (load_bcd),
        .running    (running),
        .time_out   (time_out),
        .done_pulse (done_pulse),
        .seg        (seg),
        .an         (an)
    );

    initial orig_clk = 1'b0;
    always #5 orig_clk = ~orig_clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge orig_clk);
        #1;
    endtask

    task automatic do_start(input logic [11:0] val, input logic up);
        load_bcd = val;
        mode_up  = up;
        start    = 1'b1;
        cyc(1);
        start    = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; pause = 1'b0; mode_up = 1'b0; load_bcd = 12'h000;
        cyc(3);
        total++; if (an !== 3'b111) $display("FAIL rst_an got=%b exp=111", an); else passed++;
        total++; if (seg !== 7'h7F) $display("FAIL rst_seg got=%h exp=7f", seg); else passed++;
        total++; if (running !== 1'b0) $display("FAIL rst_running got=%b exp=0", running); else passed++;
        total++; if (time_out !== 1'b0) $display("FAIL rst_time_out got=%b exp=0", time_out); else passed++;
        total++; if (done_pulse !== 1'b0) $display("FAIL rst_done got=%b exp=0", done_pulse); else passed++;
        reset = 1'b1;
        cyc(1);
        total++; if (an !== 3'b110) $display("FAIL rel_an got=%b exp=110", an); else passed++;
        total++; if (seg !== 7'h40) $display("FAIL rel_seg got=%h exp=40", seg); else passed++;
    endtask

    task automatic test_countdown;
        do_start(12'h012, 1'b0);
        total++; if (running !== 1'b1) $display("FAIL cd_running got=%b exp=1", running); else passed++;
        total++; if (dut.count !== 12'h012) $display("FAIL cd_load got=%h exp=012", dut.count); else passed++;
        cyc(9);
        total++; if (dut.count !== 12'h012) $display("FAIL cd_pre_tick got=%h exp=012", dut.count); else passed++;
        cyc(1);
        total++; if (dut.count !== 12'h011) $display("FAIL cd_tick1 got=%h exp=011", dut.count); else passed++;
        cyc(109);
        total++; if (dut.count !== 12'h001) $display("FAIL cd_last got=%h exp=001", dut.count); else passed++;
        total++; if (done_pulse !== 1'b0) $display("FAIL cd_early_done got=%b exp=0", done_pulse); else passed++;
        cyc(1);
        total++; if (dut.count !== 12'h000) $display("FAIL cd_zero got=%h exp=000", dut.count); else passed++;
        total++; if (time_out !== 1'b1) $display("FAIL cd_time_out got=%b exp=1", time_out); else passed++;
        total++; if (running !== 1'b0) $display("FAIL cd_run_fall got=%b exp=0", running); else passed++;
        total++; if (done_pulse !== 1'b1) $display("FAIL cd_done got=%b exp=1", done_pulse); else passed++;
        cyc(1);
        total++; if (done_pulse !== 1'b0) $display("FAIL cd_done_once got=%b exp=0", done_pulse); else passed++;
        cyc(20);
        total++; if (dut.count !== 12'h000 || time_out !== 1'b1)
            $display("FAIL cd_hold got=%h/%b exp=000/1", dut.count, time_out); else passed++;
    endtask

    task automatic test_borrow_and_up;
        do_start(12'h105, 1'b0);
        cyc(50);
        total++; if (dut.count !== 12'h100) $display("FAIL brw_100 got=%h exp=100", dut.count); else passed++;
        cyc(10);
        total++; if (dut.count !== 12'h099) $display("FAIL brw_099 got=%h exp=099", dut.count); else passed++;
        do_start(12'h010, 1'b1);
        total++; if (dut.count !== 12'h000) $display("FAIL up_load got=%h exp=000", dut.count); else passed++;
        cyc(90);
        total++; if (dut.count !== 12'h009 || running !== 1'b1)
            $display("FAIL up_009 got=%h/%b exp=009/1", dut.count, running); else passed++;
        cyc(10);
        total++; if (dut.count !== 12'h010) $display("FAIL up_010 got=%h exp=010", dut.count); else passed++;
        total++; if (time_out !== 1'b1 || done_pulse !== 1'b1)
            $display("FAIL up_expire got=%b/%b exp=1/1", time_out, done_pulse); else passed++;
    endtask

    task automatic test_pause;
        do_start(12'h050, 1'b0);
        cyc(13);
        total++; if (dut.count !== 12'h049) $display("FAIL pz_pre got=%h exp=049", dut.count); else passed++;
        pause = 1'b1;
        cyc(35);
        total++; if (running !== 1'b0 || time_out !== 1'b0)
            $display("FAIL pz_state got=%b/%b exp=0/0", running, time_out); else passed++;
        total++; if (dut.count !== 12'h049) $display("FAIL pz_frozen got=%h exp=049", dut.count); else passed++;
        pause = 1'b0;
        cyc(1);
        total++; if (running !== 1'b1) $display("FAIL pz_resume got=%b exp=1", running); else passed++;
        cyc(6);
        total++; if (dut.count !== 12'h049) $display("FAIL pz_phase_early got=%h exp=049", dut.count); else passed++;
        cyc(1);
        total++; if (dut.count !== 12'h048) $display("FAIL pz_phase_tick got=%h exp=048", dut.count); else passed++;
    endtask

    task automatic test_zero_and_saturate;
        do_start(12'h000, 1'b0);
        total++; if (time_out !== 1'b1 || done_pulse !== 1'b1 || running !== 1'b0)
            $display("FAIL zero_expire got=%b/%b/%b exp=1/1/0", time_out, done_pulse, running); else passed++;
        cyc(1);
        total++; if (done_pulse !== 1'b0) $display("FAIL zero_done_once got=%b exp=0", done_pulse); else passed++;
        do_start(12'h0F3, 1'b0);
        total++; if (dut.count !== 12'h093) $display("FAIL sat_load got=%h exp=093", dut.count); else passed++;
    endtask

    task automatic test_start_pause_together;
        load_bcd = 12'h123; mode_up = 1'b0; start = 1'b1; pause = 1'b1;
        cyc(1);
        start = 1'b0;
        total++; if (running !== 1'b1) $display("FAIL sp_start_wins got=%b exp=1", running); else passed++;
        cyc(1);
        total++; if (running !== 1'b0) $display("FAIL sp_pause_next got=%b exp=0", running); else passed++;
        total++; if (dut.count !== 12'h123) $display("FAIL sp_count got=%h exp=123", dut.count); else passed++;
    endtask

    task automatic test_scan;
        logic [2:0] prev;
        bit         found;
        found = 1'b0;
        prev  = an;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc(1);
            if (an == 3'b110 && prev != 3'b110) found = 1'b1;
            prev = an;
        end
        total++; if (!found) $display("FAIL scan_sync got=timeout exp=an 110 within 10 cycles"); else passed++;
        total++; if (an !== 3'b110 || seg !== 7'h30) $display("FAIL scan_d0 got=%b/%h exp=110/30", an, seg); else passed++;
        cyc(1);
        total++; if (an !== 3'b110) $display("FAIL scan_d0_hold got=%b exp=110", an); else passed++;
        cyc(1);
        total++; if (an !== 3'b101 || seg !== 7'h24) $display("FAIL scan_d1 got=%b/%h exp=101/24", an, seg); else passed++;
        cyc(2);
        total++; if (an !== 3'b011 || seg !== 7'h79) $display("FAIL scan_d2 got=%b/%h exp=011/79", an, seg); else passed++;
        cyc(2);
        total++; if (an !== 3'b110 || seg !== 7'h30) $display("FAIL scan_wrap got=%b/%h exp=110/30", an, seg); else passed++;
    endtask

    task automatic test_reset_mid_run;
        pause = 1'b0;
        cyc(5);
        total++; if (running !== 1'b1) $display("FAIL mid_pre got=%b exp=1", running); else passed++;
        reset = 1'b0;
        cyc(1);
        total++; if (an !== 3'b111 || seg !== 7'h7F) $display("FAIL mid_disp got=%b/%h exp=111/7f", an, seg); else passed++;
        total++; if (running !== 1'b0 || time_out !== 1'b0 || done_pulse !== 1'b0)
            $display("FAIL mid_flags got=%b/%b/%b exp=0/0/0", running, time_out, done_pulse); else passed++;
        total++; if (dut.count !== 12'h000) $display("FAIL mid_count got=%h exp=000", dut.count); else passed++;
        reset = 1'b1;
        cyc(1);
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow_and_up();
        test_pause();
        test_zero_and_saturate();
        test_start_pause_together();
        test_scan();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
